// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_unit
// Purpose  : Hazard and forwarding controller that sits beside the ID stage.
//            It keeps a shadow pipeline of in-flight destination records,
//            picks forwarding sources by nearest-stage priority, and detects
//            load-use hazards of any depth.
// Ports    : clock, resetn (sync, active-low)
//            id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
//            id_rn, id_wreg, id_m2reg, flush           -- ID stage inputs
//            stall                                     -- hold PC/IF-ID, bubble
//            fwda_sel, fwdb_sel (0 = regfile, k = stage k)
//            fwda_mem, fwdb_mem (forward load data from the selected stage)
//            stall_cnt, flush_cnt                      -- hazard statistics
// Config   : define HAZ_STATS_EN to build the saturating statistics
//            counters; without it both counters read 0.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_unit #(
    parameter int RW         = 5,
    parameter int DEPTH      = 2,
    parameter int LOAD_STAGE = 2,
    parameter int SW         = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic          id_use_rs,
    input  logic          id_use_rt,
    input  logic [RW-1:0] id_rn,
    input  logic          id_wreg,
    input  logic          id_m2reg,
    input  logic          flush,
    output logic          stall,
    output logic [SW-1:0] fwda_sel,
    output logic [SW-1:0] fwdb_sel,
    output logic          fwda_mem,
    output logic          fwdb_mem,
    output logic [15:0]   stall_cnt,
    output logic [15:0]   flush_cnt
);

    // Shadow pipeline, index k = stage k after ID
    logic [DEPTH:1] s_v;
    logic [DEPTH:1] s_wreg;
    logic [DEPTH:1] s_m2reg;
    logic [RW-1:0]  s_rn [1:DEPTH];

    logic [SW-1:0]  near_a, near_b;
    logic           mem_a, mem_b;
    logic           haz_a, haz_b;
    logic           issue;

    // Nearest-stage lookup: scan from the far end so the smallest matching
    // stage is the last one written. Register 0 never matches.
    always_comb begin
        near_a = '0;
        near_b = '0;
        mem_a  = 1'b0;
        mem_b  = 1'b0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (id_rs != '0 && s_v[k] && s_wreg[k] && s_rn[k] == id_rs) begin
                near_a = SW'(k);
                mem_a  = s_m2reg[k];
            end
            if (id_rt != '0 && s_v[k] && s_wreg[k] && s_rn[k] == id_rt) begin
                near_b = SW'(k);
                mem_b  = s_m2reg[k];
            end
        end
    end

    // A load that has not yet reached LOAD_STAGE cannot supply its data
    assign haz_a = (near_a != '0) && mem_a && (int'(near_a) < LOAD_STAGE);
    assign haz_b = (near_b != '0) && mem_b && (int'(near_b) < LOAD_STAGE);

    assign stall = id_valid & ~flush &
                   ((id_use_rs & haz_a) | (id_use_rt & haz_b));

    always_comb begin
        fwda_sel = '0;
        fwdb_sel = '0;
        fwda_mem = 1'b0;
        fwdb_mem = 1'b0;
        if (id_valid && !stall) begin
            if (id_use_rs) begin
                fwda_sel = near_a;
                fwda_mem = mem_a;
            end
            if (id_use_rt) begin
                fwdb_sel = near_b;
                fwdb_mem = mem_b;
            end
        end
    end

    // Only a real, non-stalled, non-flushed instruction enters stage 1;
    // everything else becomes a bubble. The shadow pipe never freezes.
    assign issue = id_valid & ~stall & ~flush;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            s_v <= '0;
        end else begin
            s_v[1] <= issue;
            for (int k = 2; k <= DEPTH; k++) begin
                s_v[k] <= s_v[k-1];
            end
        end
        // Payload fields are qualified by s_v, so they need no reset
        s_rn[1]    <= id_rn;
        s_wreg[1]  <= id_wreg;
        s_m2reg[1] <= id_m2reg;
        for (int k = 2; k <= DEPTH; k++) begin
            s_rn[k]    <= s_rn[k-1];
            s_wreg[k]  <= s_wreg[k-1];
            s_m2reg[k] <= s_m2reg[k-1];
        end
    end

`ifdef HAZ_STATS_EN
    logic [15:0] stall_q;
    logic [15:0] flush_q;

    always_ff @(posedge clock) begin
        if (!resetn) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall && stall_q != 16'hFFFF) begin
                stall_q <= stall_q + 16'd1;
            end
            if (flush && id_valid && flush_q != 16'hFFFF) begin
                flush_q <= flush_q + 16'd1;
            end
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_unit
// Purpose  : Self-checking bench for pipe_hazard_unit. A default-parameter
//            instance runs a table of per-cycle vectors; a DEPTH=3,
//            LOAD_STAGE=3 instance runs the multi-cycle stall and the
//            reset-during-stall sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_unit;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

`ifdef HAZ_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    // ---------------- default instance (DEPTH=2, LOAD_STAGE=2) -------------
    logic       a_resetn, a_valid, a_use_rs, a_use_rt, a_wreg, a_m2reg, a_flush;
    logic [4:0] a_rs, a_rt, a_rn;
    logic       a_stall, a_amem, a_bmem;
    logic [1:0] a_asel, a_bsel;
    logic [15:0] a_scnt, a_fcnt;

    pipe_hazard_unit u_dut_a (
        .clock(clock), .resetn(a_resetn), .id_valid(a_valid),
        .id_rs(a_rs), .id_rt(a_rt), .id_use_rs(a_use_rs), .id_use_rt(a_use_rt),
        .id_rn(a_rn), .id_wreg(a_wreg), .id_m2reg(a_m2reg), .flush(a_flush),
        .stall(a_stall), .fwda_sel(a_asel), .fwdb_sel(a_bsel),
        .fwda_mem(a_amem), .fwdb_mem(a_bmem),
        .stall_cnt(a_scnt), .flush_cnt(a_fcnt)
    );

    // ---------------- deep instance (DEPTH=3, LOAD_STAGE=3) ----------------
    logic       b_resetn, b_valid, b_use_rs, b_use_rt, b_wreg, b_m2reg, b_flush;
    logic [4:0] b_rs, b_rt, b_rn;
    logic       b_stall, b_amem, b_bmem;
    logic [1:0] b_asel, b_bsel;
    logic [15:0] b_scnt, b_fcnt;

    pipe_hazard_unit #(.RW(5), .DEPTH(3), .LOAD_STAGE(3)) u_dut_b (
        .clock(clock), .resetn(b_resetn), .id_valid(b_valid),
        .id_rs(b_rs), .id_rt(b_rt), .id_use_rs(b_use_rs), .id_use_rt(b_use_rt),
        .id_rn(b_rn), .id_wreg(b_wreg), .id_m2reg(b_m2reg), .flush(b_flush),
        .stall(b_stall), .fwda_sel(b_asel), .fwdb_sel(b_bsel),
        .fwda_mem(b_amem), .fwdb_mem(b_bmem),
        .stall_cnt(b_scnt), .flush_cnt(b_fcnt)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic       valid;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       use_rs;
        logic       use_rt;
        logic [4:0] rn;
        logic       wreg;
        logic       m2reg;
        logic       flush;
        logic       e_stall;
        logic [1:0] e_asel;
        logic       e_amem;
        logic [1:0] e_bsel;
        logic       e_bmem;
    } vec_t;

    function automatic vec_t mk(
        input logic v, input logic [4:0] rs, input logic [4:0] rt,
        input logic urs, input logic urt, input logic [4:0] rn,
        input logic wr, input logic m2, input logic fl,
        input logic es, input logic [1:0] ea, input logic eam,
        input logic [1:0] eb, input logic ebm);
        vec_t t;
        t.valid = v;  t.rs = rs;  t.rt = rt;  t.use_rs = urs; t.use_rt = urt;
        t.rn = rn;    t.wreg = wr; t.m2reg = m2; t.flush = fl;
        t.e_stall = es; t.e_asel = ea; t.e_amem = eam;
        t.e_bsel = eb;  t.e_bmem = ebm;
        return t;
    endfunction

    vec_t vecs [18];

    task automatic drive_b(input logic v, input logic [4:0] rs, input logic urs,
                           input logic [4:0] rn, input logic wr, input logic m2);
        b_valid = v; b_rs = rs; b_use_rs = urs; b_rt = 5'd0; b_use_rt = 1'b0;
        b_rn = rn; b_wreg = wr; b_m2reg = m2; b_flush = 1'b0;
    endtask

    initial begin : main
        //          v  rs  rt urs urt rn  wr m2 fl | st asel am bsel bm
        vecs[0]  = mk(0, 0,  0, 0, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0); // idle
        vecs[1]  = mk(1, 1,  2, 1, 1,  3, 1, 0, 0,   0, 0, 0, 0, 0); // add r3
        vecs[2]  = mk(1, 3,  1, 1, 1,  8, 1, 0, 0,   0, 1, 0, 0, 0); // sub r8,r3
        vecs[3]  = mk(1, 3,  0, 1, 0,  9, 1, 0, 0,   0, 2, 0, 0, 0); // or r9,r3
        vecs[4]  = mk(1, 1,  2, 1, 1,  4, 1, 1, 0,   0, 0, 0, 0, 0); // lw r4
        vecs[5]  = mk(1, 0,  4, 0, 1, 10, 1, 0, 0,   1, 0, 0, 0, 0); // use r4: stall
        vecs[6]  = mk(1, 0,  4, 0, 1, 10, 1, 0, 0,   0, 0, 0, 2, 1); // use r4: fwd
        vecs[7]  = mk(1, 0,  0, 0, 0,  0, 1, 0, 0,   0, 0, 0, 0, 0); // write r0
        vecs[8]  = mk(1, 0,  0, 1, 1, 11, 1, 0, 0,   0, 0, 0, 0, 0); // read r0
        vecs[9]  = mk(1, 1,  2, 1, 1,  6, 1, 0, 0,   0, 0, 0, 0, 0); // add r6
        vecs[10] = mk(1, 6,  0, 1, 0,  6, 1, 0, 0,   0, 1, 0, 0, 0); // or r6,r6
        vecs[11] = mk(1, 6,  6, 1, 1, 12, 1, 0, 0,   0, 1, 0, 1, 0); // nearest
        vecs[12] = mk(1, 0,  0, 0, 0,  7, 1, 1, 0,   0, 0, 0, 0, 0); // lw r7
        vecs[13] = mk(1, 7,  0, 1, 0, 14, 1, 0, 1,   0, 1, 1, 0, 0); // flushed dep
        vecs[14] = mk(1, 7,  0, 1, 0, 13, 1, 0, 0,   0, 2, 1, 0, 0); // r7 at stage 2
        vecs[15] = mk(0, 13, 0, 1, 0,  0, 0, 0, 0,   0, 0, 0, 0, 0); // invalid
        vecs[16] = mk(1, 13, 0, 1, 0,  0, 0, 0, 0,   0, 2, 0, 0, 0); // bubble went in
        vecs[17] = mk(0, 0,  0, 0, 0,  0, 0, 0, 1,   0, 0, 0, 0, 0); // flush, no valid

        a_resetn = 1'b0; a_valid = 0; a_rs = 0; a_rt = 0; a_use_rs = 0;
        a_use_rt = 0; a_rn = 0; a_wreg = 0; a_m2reg = 0; a_flush = 0;
        b_resetn = 1'b0;
        drive_b(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clock);
        #1;
        a_resetn = 1'b1;
        b_resetn = 1'b1;

        @(negedge clock);
        check("reset_stall", {15'd0, a_stall}, 16'd0);
        check("reset_asel", {14'd0, a_asel}, 16'd0);
        check("reset_scnt", a_scnt, 16'd0);
        check("reset_fcnt", a_fcnt, 16'd0);
        @(posedge clock);
        #1;

        for (int i = 0; i < 18; i++) begin
            a_valid = vecs[i].valid; a_rs = vecs[i].rs; a_rt = vecs[i].rt;
            a_use_rs = vecs[i].use_rs; a_use_rt = vecs[i].use_rt;
            a_rn = vecs[i].rn; a_wreg = vecs[i].wreg; a_m2reg = vecs[i].m2reg;
            a_flush = vecs[i].flush;
            @(negedge clock);
            check($sformatf("v%0d_stall", i), {15'd0, a_stall}, {15'd0, vecs[i].e_stall});
            check($sformatf("v%0d_asel", i), {14'd0, a_asel}, {14'd0, vecs[i].e_asel});
            check($sformatf("v%0d_amem", i), {15'd0, a_amem}, {15'd0, vecs[i].e_amem});
            check($sformatf("v%0d_bsel", i), {14'd0, a_bsel}, {14'd0, vecs[i].e_bsel});
            check($sformatf("v%0d_bmem", i), {15'd0, a_bmem}, {15'd0, vecs[i].e_bmem});
            if (i == 6) check("a_scnt_after_load_use", a_scnt, STATS ? 16'd1 : 16'd0);
            @(posedge clock);
            #1;
        end
        check("a_scnt_final", a_scnt, STATS ? 16'd1 : 16'd0);
        check("a_fcnt_final", a_fcnt, STATS ? 16'd1 : 16'd0);

        // ---- deep instance: load two stages short of LOAD_STAGE ----
        drive_b(1, 0, 0, 5, 1, 1);                       // lw r5
        @(negedge clock);
        check("b_lw_stall", {15'd0, b_stall}, 16'd0);
        @(posedge clock); #1;
        drive_b(1, 5, 1, 14, 1, 0);                      // reader of r5
        for (int c = 0; c < 2; c++) begin
            @(negedge clock);
            check($sformatf("b_stall_c%0d", c), {15'd0, b_stall}, 16'd1);
            check($sformatf("b_asel_c%0d", c), {14'd0, b_asel}, 16'd0);
            @(posedge clock); #1;
        end
        @(negedge clock);
        check("b_release_stall", {15'd0, b_stall}, 16'd0);
        check("b_release_asel", {14'd0, b_asel}, 16'd3);
        check("b_release_amem", {15'd0, b_amem}, 16'd1);
        check("b_scnt", b_scnt, STATS ? 16'd2 : 16'd0);
        @(posedge clock); #1;

        // ---- deep instance: reset pulse in the middle of a stall ----
        drive_b(1, 0, 0, 5, 1, 1);                       // lw r5
        @(posedge clock); #1;
        drive_b(1, 5, 1, 15, 1, 0);                      // reader of r5
        @(negedge clock);
        check("b_rst_pre_stall", {15'd0, b_stall}, 16'd1);
        b_resetn = 1'b0;
        @(posedge clock); #1;
        b_resetn = 1'b1;
        @(negedge clock);
        check("b_rst_stall", {15'd0, b_stall}, 16'd0);
        check("b_rst_asel", {14'd0, b_asel}, 16'd0);
        check("b_rst_bsel", {14'd0, b_bsel}, 16'd0);
        check("b_rst_scnt", b_scnt, 16'd0);
        check("b_rst_fcnt", b_fcnt, 16'd0);
        @(posedge clock); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard and forwarding controller for the pipelined CPU, the successor to the fixed E/M forwarding logic in the decode-stage control unit. It keeps its own shadow pipeline of in-flight destination-register records and resolves operand sources by nearest-stage priority. It detects load-use hazards of any depth and produces the stall and bubble-injection decisions. It sits beside the ID stage and drives the operand muxes and the PC/IF-ID write enables.

## Interface
- RW, 5: register-address width
- DEPTH, 2: tracked in-flight stages after ID (1 = E, 2 = M, …); legal range 1..7
- LOAD_STAGE, 2: first stage (1-based) at which load data can be forwarded; legal range 1..DEPTH
- SW, derived: $clog2(DEPTH+1), width of the select outputs
- clock  in  1  sole clock, rising edge
- resetn  in  1  synchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  RW  source register numbers
- id_use_rs, id_use_rt  in  1  instruction actually reads rs/rt
- id_rn  in  RW  destination register of the ID instruction
- id_wreg  in  1  ID instruction writes a register
- id_m2reg  in  1  ID instruction is a load
- flush  in  1  kill the ID instruction this cycle (taken control transfer)
- stall  out  1  hold PC and IF/ID; inject bubble into stage 1
- fwda_sel, fwdb_sel  out  SW  0 = register file, k = stage k
- fwda_mem, fwdb_mem  out  1  forward load data (not ALU result) from stage fwd*_sel
- stall_cnt, flush_cnt  out  16  hazard statistics (see Configuration)

## Operation
- Shadow entry per stage k (1..DEPTH): {v, rn, wreg, m2reg}.
- Match(r, k): r != 0 && v[k] && wreg[k] && rn[k] == r. Register 0 never matches.
- Nearest(r): the smallest k with Match(r, k); none → 0.
- Hazard(r): Nearest(r) = k > 0 && m2reg[k] && k < LOAD_STAGE.
- stall = id_valid & ~flush & ((id_use_rs & Hazard(id_rs)) | (id_use_rt & Hazard(id_rt))).
- When stall = 0: fwda_sel = Nearest(id_rs) if id_use_rs, else 0. fwda_mem = m2reg of that stage when fwda_sel != 0. fwdb_* follows the same rule using rt.
- When stall = 1: all fwd* outputs are forced to 0.
- Advance each clock:
  - s[k] <= s[k-1] for k >= 2.
  - s[1] <= {1, id_rn, id_wreg, id_m2reg} if id_valid & ~stall & ~flush; otherwise s[1] <= bubble (v = 0).
- The shadow pipeline never freezes. A stall only inserts a bubble, so a load ahead of the stalled instruction keeps advancing.
- flush takes priority over stall in the same cycle: stall = 0 and a bubble is inserted.
- id_valid = 0: stall = 0, all fwd outputs 0, bubble inserted.

## Timing
- stall and fwd* outputs are combinational from the ID inputs and the registered shadow state, valid in the same cycle. There are no registered outputs except the counters.
- Stall length for a load at stage j with a dependent instruction in ID is LOAD_STAGE − j cycles. At defaults, an immediately-following dependent instruction stalls 1 cycle and then gets sel = 2, mem = 1.
- Reset (resetn = 0 at an edge): every shadow v <= 0 and the counters <= 0. The cycle after reset, stall = 0 and fwd* = 0 regardless of inputs except ID matches, which cannot occur.
- Reset asserted during a multi-cycle stall clears the shadow pipeline, so the stall ends the next cycle.

## Configuration
- HAZ_STATS_EN defined:
  - stall_cnt increments on every clock with stall = 1.
  - flush_cnt increments on every clock with flush = 1 & id_valid.
  - Both saturate at 16'hFFFF and clear on reset.
- HAZ_STATS_EN undefined: no counter registers exist, and stall_cnt and flush_cnt are tied to 0.

## Test plan
- Defaults; `add r3` in ID, next cycle `sub` reading r3 in rs → fwda_sel = 1, fwda_mem = 0, stall = 0. One cycle later, a reader of r3 → fwda_sel = 2, fwda_mem = 0.
- Defaults; `lw r4` then immediately a reader of r4 in rt:
  - first cycle stall = 1, fwdb = 0;
  - next cycle stall = 0, fwdb_sel = 2, fwdb_mem = 1;
  - stall_cnt = 1 with HAZ_STATS_EN.
- DEPTH = 3, LOAD_STAGE = 3; `lw r5` then a reader of r5 → stall for exactly 2 cycles, then fwda_sel = 3, fwda_mem = 1.
- Instructions writing r0, then a reader of r0 → sel = 0, stall = 0. `add r6` then `or r6` then a reader of r6 → sel = 1 (nearest wins).
- `lw r7` then dependent in ID with flush = 1 the same cycle → stall = 0 and the bubble enters s[1]. Next cycle, a reader of r7 (load now at stage 2) → sel = 2, mem = 1, no stall.
- A 1-cycle resetn = 0 pulse mid-stall (DEPTH = 3, LOAD_STAGE = 3) → the next cycle stall = 0, all sel = 0, and the counters read 0.
